fir_mac_scheduler: RTL

Time-multiplexed FIR controller: accepts one `input_sig` sample per `ready` strobe, stores it in a circular delay line, and sequences a single shared multiply-accumulate across `TAPS` coefficients read from an external synchronous coefficient ROM. It is the area-lean sibling of `fir_filter` / `fir_filter_sep` and sits behind the same `input_sig` / `ready` source. It produces a saturated `filtred_sig` with a one-cycle `sig_valid` strobe.

---
 rtl/fir_ctrl_pkg.sv | 22 ++
 rtl/fir_mac_sat.sv | 46 ++++
 rtl/fir_mac_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the time-multiplexed FIR controller.
// Default widths and the accumulator sizing helper live here.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_TAIL,
        ST_DONE
    } fir_state_t;

    localparam int DEF_WIDTH      = 20;
    localparam int DEF_TAPS       = 16;
    localparam int DEF_COEF_WIDTH = 16;
    localparam int COEF_FRAC      = DEF_COEF_WIDTH - 1;

    // Full product plus log2(taps) guard bits, so summing every tap cannot overflow.
    function automatic int acc_width(input int width, input int coef_width, input int taps);
        return width + coef_width + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// Registered multiply-accumulate with synchronous clear, followed by the
// Q1.(COEF_WIDTH-1) rescale and saturation down to WIDTH bits.
module fir_mac_sat #(
    parameter int WIDTH      = 20,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_W      = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [COEF_WIDTH-1:0] coef,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] result
);
    localparam int PW = WIDTH + COEF_WIDTH;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0]    product;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;

    assign product = coef * sample;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-PW){product[PW-1]}}, product};
        end
    end

    // Arithmetic shift floors toward -inf, then clamp into the output range.
    assign shifted = acc >>> (COEF_WIDTH - 1);

    always_comb begin
        result = shifted[WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller: circular delay line, coefficient ROM
// address sequencing and a single shared MAC, one sample per TAPS+3 cycles.
module fir_mac_scheduler
    import fir_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TAPS       = DEF_TAPS,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [WIDTH-1:0]      input_sig,
    input  logic                         ready,
    output logic [$clog2(TAPS)-1:0]      coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic signed [WIDTH-1:0]      filtred_sig,
    output logic                         sig_valid,
    output logic                         busy,
    output logic                         overrun,
    output fir_state_t                   fsm_state
);
    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = acc_width(WIDTH, COEF_WIDTH, TAPS);

    fir_state_t state, next_state;

    logic signed [WIDTH-1:0] mem [TAPS];
    logic [AW-1:0]           wp;
    logic [AW-1:0]           base;
    logic [AW-1:0]           k;
    logic                    tail_cnt;
    logic                    tap_v;
    logic signed [WIDTH-1:0] samp_q;
    logic signed [WIDTH-1:0] mac_result;
    logic                    accept;
    logic                    issue;

    assign accept = (state == ST_IDLE) && ready;
    // The last address goes out during the first TAIL cycle; the second only drains.
    assign issue  = (state == ST_MAC) || ((state == ST_TAIL) && !tail_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (ready) next_state = ST_MAC;
            ST_MAC:  if (k == AW'(TAPS - 2)) next_state = ST_TAIL;
            ST_TAIL: if (tail_cnt) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) mem[i] <= '0;
            wp          <= '0;
            base        <= '0;
            k           <= '0;
            tail_cnt    <= 1'b0;
            tap_v       <= 1'b0;
            samp_q      <= '0;
            filtred_sig <= '0;
            sig_valid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sig_valid <= (state == ST_DONE);
            overrun   <= ready && (state != ST_IDLE);
            tail_cnt  <= (state == ST_TAIL) && !tail_cnt;
            // Sample is fetched in the same cycle the ROM reads, so both arrive together.
            tap_v     <= issue;
            samp_q    <= mem[base - k];
            if (accept) begin
                mem[wp] <= input_sig;
                base    <= wp;
                wp      <= wp + AW'(1);
                k       <= '0;
            end
            if (state == ST_MAC) begin
                k <= k + AW'(1);
            end
            if (state == ST_DONE) begin
                filtred_sig <= mac_result;
            end
        end
    end

    fir_mac_sat #(
        .WIDTH      (WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_W      (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .en     (tap_v),
        .coef   (coef_data),
        .sample (samp_q),
        .result (mac_result)
    );

    assign coef_addr = k;
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule
